// File: rtl/rho_rotate_lanes.sv
// Keccak-f[1600] rho step, one lane per clock.
// The state is latched on an accepted start, then lanes 0..24 are rotated in
// place by their fixed offsets. A one-cycle write_file pulse marks completion
// and doubles as the trigger for the downstream file dumper.
module rho_rotate_lanes (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    file_index_in,
  input  logic [1599:0] data_in,
  output logic          ready,
  output logic [1599:0] data_out,
  output logic          write_file,
  output logic [9:0]    file_index
);

  typedef enum logic [0:0] {StIdle, StRot} state_e;

  state_e        state_q, state_d;
  logic [4:0]    lane_q, lane_d;
  logic [1599:0] data_q, data_d;
  logic [9:0]    index_q, index_d;
  logic          wr_q, wr_d;

  logic [5:0]    rho_off;
  logic [63:0]   lane_val;
  logic [127:0]  lane_dbl;
  logic [63:0]   lane_rot;

  // Rho offset ROM indexed by lane number l = 5*y + x.
  function automatic logic [5:0] rho_offset(input logic [4:0] l);
    logic [5:0] r;
    case (l)
      5'd0:    r = 6'd0;
      5'd1:    r = 6'd1;
      5'd2:    r = 6'd62;
      5'd3:    r = 6'd28;
      5'd4:    r = 6'd27;
      5'd5:    r = 6'd36;
      5'd6:    r = 6'd44;
      5'd7:    r = 6'd6;
      5'd8:    r = 6'd55;
      5'd9:    r = 6'd20;
      5'd10:   r = 6'd3;
      5'd11:   r = 6'd10;
      5'd12:   r = 6'd43;
      5'd13:   r = 6'd25;
      5'd14:   r = 6'd39;
      5'd15:   r = 6'd41;
      5'd16:   r = 6'd45;
      5'd17:   r = 6'd15;
      5'd18:   r = 6'd21;
      5'd19:   r = 6'd8;
      5'd20:   r = 6'd18;
      5'd21:   r = 6'd2;
      5'd22:   r = 6'd61;
      5'd23:   r = 6'd56;
      5'd24:   r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Gather the current lane (bit z sits at 25*z + lane) and rotate it toward higher z.
  always_comb begin
    rho_off  = rho_offset(lane_q);
    lane_val = '0;
    for (int z = 0; z < 64; z++) begin
      lane_val[z] = data_q[11'(25 * z) + 11'(lane_q)];
    end
    // Upper half of the doubled lane shifted left is the left-rotate.
    lane_dbl = {lane_val, lane_val} << rho_off;
    lane_rot = lane_dbl[127:64];
  end

  // Next-state: accept in idle, otherwise scatter the rotated lane back and advance.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    index_d = index_q;
    wr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRot;
          data_d  = data_in;
          index_d = file_index_in;
          lane_d  = 5'd0;
        end
      end
      StRot: begin
        for (int z = 0; z < 64; z++) begin
          data_d[11'(25 * z) + 11'(lane_q)] = lane_rot[z];
        end
        if (lane_q == 5'd24) begin
          state_d = StIdle;
          lane_d  = 5'd0;
          wr_d    = 1'b1;
        end else begin
          lane_d = lane_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lane_q  <= 5'd0;
      data_q  <= '0;
      index_q <= 10'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      index_q <= index_d;
      wr_q    <= wr_d;
    end
  end

  assign ready      = (state_q == StIdle);
  assign data_out   = data_q;
  assign write_file = wr_q;
  assign file_index = index_q;

endmodule

// File: tb/tb_rho_rotate_lanes.sv
// Directed bench for rho_rotate_lanes with an independent index-based rho model.
module tb_rho_rotate_lanes;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    file_index_in;
  logic [1599:0] data_in;
  logic          ready;
  logic [1599:0] data_out;
  logic          write_file;
  logic [9:0]    file_index;

  int checks = 0;
  int errors = 0;

  localparam int RHO [25] = '{0, 1, 62, 28, 27,
                              36, 44, 6, 55, 20,
                              3, 10, 43, 25, 39,
                              41, 45, 15, 21, 8,
                              18, 2, 61, 56, 14};

  rho_rotate_lanes dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .file_index_in(file_index_in),
    .data_in      (data_in),
    .ready        (ready),
    .data_out     (data_out),
    .write_file   (write_file),
    .file_index   (file_index)
  );

  always #5 clk = ~clk;

  function automatic logic [1599:0] rho_ref(input logic [1599:0] a);
    logic [1599:0] o;
    o = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < 64; z++)
          o[25 * z + 5 * y + x] = a[25 * ((z - RHO[5 * y + x] + 64) % 64) + 5 * y + x];
    return o;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int w = 0; w < 50; w++) v[w * 32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [1599:0] one_bit(input int idx);
    logic [1599:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [1599:0] got,
                            input logic [1599:0] exp);
    int nd;
    checks++;
    assert (got === exp) else begin
      errors++;
      nd = 0;
      for (int i = 0; i < 1600; i++) if (got[i] !== exp[i]) nd++;
      $error("FAIL %s: observed low64 %h expected low64 %h (%0d bits differ)",
             tag, got[63:0], exp[63:0], nd);
    end
  endtask

  // Drive start for one edge, return sampled #1 after the accepting edge.
  task automatic accept(input logic [9:0] idx, input logic [1599:0] d);
    start         = 1'b1;
    file_index_in = idx;
    data_in       = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until write_file; also count samples with ready low (entry sample included).
  task automatic wait_done(input string tag, input int exp_n);
    int n;
    int low;
    n   = 0;
    low = (ready === 1'b0) ? 1 : 0;
    while (write_file !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready === 1'b0) low++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_n));
    check({tag, " ready_low"}, 64'(low), 64'(exp_n));
    check({tag, " ready_at_pulse"}, 64'(ready), 64'd1);
  endtask

  task automatic run_one(input string tag, input logic [9:0] idx, input logic [1599:0] d,
                         input logic [1599:0] exp);
    accept(idx, d);
    wait_done(tag, 25);
    check_data({tag, " data"}, data_out, exp);
    check({tag, " index"}, 64'(file_index), 64'(idx));
  endtask

  initial begin
    logic [1599:0] a;
    logic [1599:0] b;
    int seen;

    rst = 1'b1; start = 1'b0; file_index_in = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    check("rst ready", 64'(ready), 64'd1);
    check("rst write_file", 64'(write_file), 64'd0);
    check_data("rst data", data_out, '0);
    check("rst index", 64'(file_index), 64'd0);

    // Zero state, index 3; pulse is a single cycle
    run_one("zero", 10'd3, '0, '0);
    @(posedge clk); #1;
    check("zero pulse_width", 64'(write_file), 64'd0);

    // Single-bit lanes with hand-computed targets
    run_one("bit1", 10'd1, one_bit(1), one_bit(26));
    run_one("bit2", 10'd2, one_bit(2), one_bit(1552));
    run_one("bit24", 10'd4, one_bit(24), one_bit(374));

    // All ones
    run_one("ones", 10'd5, '1, '1);

    // Random vectors against the model
    for (int k = 0; k < 100; k++) begin
      a = rand_state();
      run_one("rand", 10'(k), a, rho_ref(a));
    end

    // Start during ROT is ignored
    a = rand_state();
    b = rand_state();
    accept(10'd11, a);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; file_index_in = 10'd12; data_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", 20);
    check_data("ignore data", data_out, rho_ref(a));
    check("ignore index", 64'(file_index), 64'd11);
    @(posedge clk); #1;
    check("ignore no_restart", 64'(ready), 64'd1);

    // Back-to-back: start held, accepted again in the write_file cycle
    a = rand_state();
    b = rand_state();
    start = 1'b1; file_index_in = 10'd7; data_in = a;
    @(posedge clk); #1;
    file_index_in = 10'd8; data_in = b;
    wait_done("b2b first", 25);
    check_data("b2b first data", data_out, rho_ref(a));
    check("b2b first index", 64'(file_index), 64'd7);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b reaccept ready", 64'(ready), 64'd0);
    check("b2b reaccept index", 64'(file_index), 64'd8);
    wait_done("b2b second", 25);
    check_data("b2b second data", data_out, rho_ref(b));
    check("b2b second index", 64'(file_index), 64'd8);

    // Reset in the middle of ROT
    accept(10'd9, rand_state());
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst ready", 64'(ready), 64'd1);
    check_data("midrst data", data_out, '0);
    check("midrst index", 64'(file_index), 64'd0);
    seen = 0;
    repeat (30) begin
      if (write_file === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("midrst no_pulse", 64'(seen), 64'd0);

    // Reset wins over start in the same cycle
    rst = 1'b1; start = 1'b1; file_index_in = 10'd13; data_in = '1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio ready", 64'(ready), 64'd1);
    check("rst_prio index", 64'(file_index), 64'd0);

    // Normal run after reset
    a = rand_state();
    run_one("post_rst", 10'd10, a, rho_ref(a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
